// File: rtl/my_uart_rx.sv
// my_uart_rx: UART receiver, 8N1 by default, with a one-cycle valid strobe.
// Each bit is sampled at its middle. A stop bit sampled low is reported as
// a framing error. The last good byte is held on Rx_Data and mirrored to LEDOut.
// Build option: define UART_RX_PARITY_EN to receive 8E1 frames (even parity).
// In that build a parity mismatch pulses Rx_ParityErr.
module my_uart_rx #(
  parameter int ClocksPerBit = 10417   // Clk cycles per bit, must be >= 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] Rx_Data,
  output logic       Rx_DataValid,
  output logic       Rx_FrameErr,
  output logic       Rx_ParityErr,
  output logic       Rx_Busy,
  output logic [7:0] LEDOut
);

  localparam int CntW    = $clog2(ClocksPerBit);
  localparam int HalfBit = (ClocksPerBit - 1) / 2;
  localparam logic [CntW-1:0] HalfCnt = HalfBit[CntW-1:0];
  localparam logic [CntW-1:0] LastCnt = CntW'(ClocksPerBit - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
`endif
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_CLEANUP = 3'd5;

  logic            sync1_q, sync2_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_s;

  assign rx_s = sync2_q;

`ifdef UART_RX_PARITY_EN
  logic mismatch_q, mismatch_d;
  logic par_err_q, par_err_d;
`endif

  // Next-state, counter, shift register and strobe logic.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = '0;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    mismatch_d  = mismatch_q;
    par_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HalfCnt) begin
          // A line that is high again at mid-start-bit was a glitch.
          state_d   = rx_s ? S_IDLE : S_DATA;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LastCnt) begin
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LastCnt) begin
          mismatch_d = rx_s ^ (^shift_q);
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LastCnt) begin
          // A framing error takes precedence over a parity error.
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (mismatch_q) begin
            par_err_d = 1'b1;
          end
`endif
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
          state_d = S_CLEANUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEANUP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Two-flop synchronizer plus all receiver state registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples values from before the edge.
      sync1_q     <= Rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag and parity error strobe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mismatch_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
      par_err_q  <= par_err_d;
    end
  end
  assign Rx_ParityErr = par_err_q;
`else
  assign Rx_ParityErr = 1'b0;
`endif

  assign Rx_Data      = data_q;
  assign LEDOut       = data_q;
  assign Rx_DataValid = valid_q;
  assign Rx_FrameErr  = frame_err_q;
  assign Rx_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_my_uart_rx.sv
// tb_my_uart_rx: directed self-checking bench for my_uart_rx.
// Uses a short bit period (32 clocks) so that each frame stays brief.
// Define UART_RX_PARITY_EN to exercise the 8E1 variant.
module tb_my_uart_rx;

  localparam int CPB = 32;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx;
  logic [7:0] Rx_Data;
  logic       Rx_DataValid;
  logic       Rx_FrameErr;
  logic       Rx_ParityErr;
  logic       Rx_Busy;
  logic [7:0] LEDOut;

  int checks_total  = 0;
  int checks_passed = 0;

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         perr_cnt  = 0;
  logic [7:0] cap [0:15];

  my_uart_rx #(.ClocksPerBit(CPB)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Rx           (Rx),
    .Rx_Data      (Rx_Data),
    .Rx_DataValid (Rx_DataValid),
    .Rx_FrameErr  (Rx_FrameErr),
    .Rx_ParityErr (Rx_ParityErr),
    .Rx_Busy      (Rx_Busy),
    .LEDOut       (LEDOut)
  );

  always #5 Clk = ~Clk;

  // Count strobes on the falling edge and capture the byte for each valid pulse.
  always @(negedge Clk) begin
    if (Rx_DataValid) begin
      if (valid_cnt < 16) cap[valid_cnt] = Rx_Data;
      valid_cnt++;
    end
    if (Rx_FrameErr)  ferr_cnt++;
    if (Rx_ParityErr) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    cycles(CPB);
  endtask

  // One frame: start, 8 data bits LSB first, optional parity, stop.
  // par_flip inverts the correct even-parity bit.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) drive_bit(1'b1);   // unused in the 8N1 build
`endif
    drive_bit(stop_bit);
    Rx = 1'b1;
  endtask

  initial begin
    logic [7:0] b3c;
    b3c = 8'h3C;
    Rst = 1'b1;
    Rx  = 1'b1;
    cycles(3);
    check("rst_data",   Rx_Data,      8'h00);
    check("rst_led",    LEDOut,       8'h00);
    check("rst_valid",  Rx_DataValid, 1'b0);
    check("rst_ferr",   Rx_FrameErr,  1'b0);
    check("rst_perr",   Rx_ParityErr, 1'b0);
    check("rst_busy",   Rx_Busy,      1'b0);
    Rst = 1'b0;
    cycles(2 * CPB);

    // Single clean byte.
    send_byte(8'h61, 1'b1, 1'b0);
    cycles(8);
    check("b1_valid_cnt", valid_cnt, 1);
    check("b1_cap",       cap[0],    8'h61);
    check("b1_data",      Rx_Data,   8'h61);
    check("b1_led",       LEDOut,    8'h61);
    check("b1_ferr_cnt",  ferr_cnt,  0);
    check("b1_busy",      Rx_Busy,   1'b0);

    // Two bytes back-to-back with no idle gap.
    send_byte(8'h61, 1'b1, 1'b0);
    send_byte(8'h63, 1'b1, 1'b0);
    cycles(8);
    check("b2b_valid_cnt", valid_cnt, 3);
    check("b2b_cap1",      cap[1],    8'h61);
    check("b2b_cap2",      cap[2],    8'h63);
    check("b2b_data",      Rx_Data,   8'h63);

    // Glitch shorter than half a bit: enters START, then drops back to IDLE.
    Rx = 1'b0;
    cycles(4);
    check("glitch_busy_hi", Rx_Busy, 1'b1);
    Rx = 1'b1;
    cycles(2 * CPB);
    check("glitch_valid_cnt", valid_cnt, 3);
    check("glitch_ferr_cnt",  ferr_cnt,  0);
    check("glitch_data",      Rx_Data,   8'h63);
    check("glitch_busy",      Rx_Busy,   1'b0);

    // Stop bit forced low: framing error only, data held.
    send_byte(8'hA5, 1'b0, 1'b0);
    cycles(8);
    check("ferr_cnt",       ferr_cnt,  1);
    check("ferr_valid_cnt", valid_cnt, 3);
    check("ferr_data",      Rx_Data,   8'h63);
    check("ferr_led",       LEDOut,    8'h63);
    cycles(CPB);

    // Reset during bit 4 of a 0x3C frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b3c[i]);
    Rx = b3c[4];
    cycles(CPB / 3);
    check("mid_busy_before", Rx_Busy, 1'b1);
    Rst = 1'b1;
    #1;
    check("mid_rst_data",  Rx_Data,      8'h00);
    check("mid_rst_led",   LEDOut,       8'h00);
    check("mid_rst_busy",  Rx_Busy,      1'b0);
    check("mid_rst_valid", Rx_DataValid, 1'b0);
    cycles(2);
    Rst = 1'b0;
    Rx  = 1'b1;
    cycles(2 * CPB);
    check("mid_no_strobe", valid_cnt + ferr_cnt, 4);
    send_byte(8'h3C, 1'b1, 1'b0);
    cycles(8);
    check("post_rst_valid_cnt", valid_cnt, 4);
    check("post_rst_data",      Rx_Data,   8'h3C);
    check("post_rst_led",       LEDOut,    8'h3C);

`ifdef UART_RX_PARITY_EN
    // 0x61 has three ones, so its even-parity bit is 1.
    send_byte(8'h61, 1'b1, 1'b0);
    cycles(8);
    check("par_ok_valid_cnt", valid_cnt, 5);
    check("par_ok_data",      Rx_Data,   8'h61);
    check("par_ok_perr_cnt",  perr_cnt,  0);
    send_byte(8'h61, 1'b1, 1'b1);
    cycles(8);
    check("par_bad_perr_cnt",  perr_cnt,  1);
    check("par_bad_valid_cnt", valid_cnt, 5);
    check("par_bad_ferr_cnt",  ferr_cnt,  1);
    send_byte(8'h3C, 1'b1, 1'b1);
    cycles(8);
    check("par_bad2_perr_cnt", perr_cnt, 2);
    check("par_bad2_data",     Rx_Data,  8'h61);
`else
    check("no_parity_perr_cnt", perr_cnt, 0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/my_uart_rx.md
Name: my_uart_rx

Overview:
- 8N1 UART receiver, the receive counterpart of the team's UART transmitter. Targets the Basys-3 100 MHz clock.
- Asynchronous serial line in; deserialized byte plus one-cycle valid strobe out.
- Start bit validated at mid-bit; data and stop bits sampled at mid-bit; framing errors flagged.
- Last good byte mirrored to the board LEDs for bring-up.

Parameters:
- ClocksPerBit, 10417: Clk cycles per bit (100 MHz / 9600 baud). Must be >= 4.
- HalfBit, (ClocksPerBit-1)/2 = 5208: mid-start-bit sample point. Derived localparam, not overridable.

Ports:
- Clk  input  1  system clock, 100 MHz
- Rst  input  1  reset, asynchronous, active-high
- Rx  input  1  serial line, idle high, asynchronous to Clk
- Rx_Data  output  8  last correctly received byte
- Rx_DataValid  output  1  one-cycle pulse; Rx_Data updated on the same cycle
- Rx_FrameErr  output  1  one-cycle pulse; stop bit sampled low
- Rx_ParityErr  output  1  one-cycle pulse on parity mismatch (see Optional Feature)
- Rx_Busy  output  1  high whenever the FSM is not in IDLE
- LEDOut  output  8  copy of Rx_Data for the board LEDs

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values:
  - Rx_Data, LEDOut = 8'h00.
  - Rx_DataValid, Rx_FrameErr, Rx_ParityErr, Rx_Busy = 0.
  - Both synchronizer FFs = 1 (idle line).
  - FSM = IDLE; counter and bit index = 0.
- Synchronizer: Rx passes through 2 FFs to give Rx_s; all logic uses Rx_s only. This adds 2 cycles of input latency.
- Counter: width $clog2(ClocksPerBit). Cleared on every state change.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, CLEANUP.
  - IDLE: Rx_s==0 -> START.
  - START: counter counts up. At counter==HalfBit: if Rx_s==0 -> DATA (counter cleared, bit index 0); else -> IDLE, treated as a glitch with no outputs.
  - DATA: at counter==ClocksPerBit-1, Rx_s is shifted into shift_reg[bit index], LSB first. After bit index 7 -> STOP, or -> PARITY when the macro is defined; otherwise bit index increments.
  - STOP: at counter==ClocksPerBit-1, sample Rx_s:
    - 1 with no parity error: Rx_Data and LEDOut <= shift_reg; Rx_DataValid=1 for exactly 1 cycle.
    - 0: Rx_FrameErr=1 for 1 cycle; Rx_Data and LEDOut are unchanged.
    - Then -> CLEANUP.
  - CLEANUP: 1 cycle; clears the strobes; -> IDLE.
- Because sampling ends at mid-stop-bit, the block is back in IDLE about half a bit early. A back-to-back start bit is therefore caught without loss.
- Latency: Rx_DataValid asserts 2 + HalfBit + 9*ClocksPerBit + ~3 cycles after the Rx falling edge, about 9.5 bit periods. The exact count is implementation-defined within ±3 cycles.
- Rx_DataValid, Rx_FrameErr and Rx_ParityErr are mutually exclusive. At most one strobe is asserted per frame.
- Line held low (break): START -> DATA; all-zero data; stop bit low gives Rx_FrameErr. CLEANUP -> IDLE then immediately -> START again. No lockup.
- Rst mid-frame: immediate return to reset values; partial byte discarded; no strobe.
- No backpressure: a consumer that misses the strobe loses the byte. Rx_Data holds until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1 (even parity).
  - PARITY state samples one extra bit at ClocksPerBit-1. It records mismatch = sampled bit XOR (^shift_reg).
  - In STOP with stop bit high and mismatch: Rx_ParityErr pulses for 1 cycle and Rx_DataValid does not. Rx_Data is unchanged.
  - A stop bit low gives Rx_FrameErr, which takes precedence over parity.
- Undefined:
  - 8N1 frame; PARITY state absent.
  - Rx_ParityErr is tied 0.

Test Plan:
- Reset, then Rx idle high for 2 bit periods; send 8N1 byte 0x61 at 9600 baud (bit period 104170 ns) -> one Rx_DataValid pulse; Rx_Data=LEDOut=8'h61; Rx_FrameErr=0; Rx_Busy back to 0.
- Send 0x61 then 0x63 back-to-back with no idle gap -> two DataValid pulses; Rx_Data=8'h61 then 8'h63.
- Pulse Rx low for 2000 ns (shorter than a half bit) -> returns to IDLE; no strobes; Rx_Data unchanged.
- Send 0xA5 with stop bit forced low -> Rx_FrameErr pulse only; Rx_Data keeps its previous value 8'h63.
- Assert Rst during bit 4 of a 0x3C frame -> all outputs at reset values within one Clk. A subsequent clean 0x3C frame gives Rx_Data=8'h3C.
- With UART_RX_PARITY_EN: 0x61 with parity bit 1 -> DataValid. 0x61 with parity bit 0 -> Rx_ParityErr pulse; Rx_Data unchanged.
